// File: rtl/bs_cmd_sequencer.sv
// Command queue, issue register and result register around a barrel shifter.
// Optional BS_SELF_CHECK_EN adds a sticky err_flag from a shadow shifter.
module bs_cmd_sequencer #(
   parameter int DATA_W     = 32,
   parameter int AMT_W      = 5,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [DATA_W-1:0]           cmd_data,
   input  logic [AMT_W-1:0]            cmd_amt,
   input  logic                        cmd_left_right,
   input  logic                        cmd_shift_rotate,
   output logic [DATA_W-1:0]           bs_data_in,
   output logic [AMT_W-1:0]            bs_shift_amt,
   output logic                        bs_left_right,
   output logic                        bs_shift_rotate,
   input  logic [DATA_W-1:0]           bs_data_out,
   output logic                        res_valid,
   input  logic                        res_ready,
   output logic [DATA_W-1:0]           res_data,
`ifdef BS_SELF_CHECK_EN
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        err_flag
`else
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = DATA_W + AMT_W + 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [EW-1:0]     mem_q [FIFO_DEPTH];
   logic [EW-1:0]     mem_d [FIFO_DEPTH];
   logic [EW-1:0]     iss_q, iss_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic              res_valid_q, res_valid_d;
   logic              rdy_en_q;
   logic              push, pop, empty;

`ifdef BS_SELF_CHECK_EN
   logic err_q, err_d;

   function automatic logic [DATA_W-1:0] shf(
      input logic [EW-1:0] c
   );
      logic [DATA_W-1:0] d;
      int                a;
      d = c[DATA_W-1:0];
      a = int'(c[DATA_W+AMT_W-1:DATA_W]);
      if (c[EW-1])
         shf = (d << a) |
               (c[EW-2] ? d >> (DATA_W - a) : '0);
      else
         shf = (d >> a) |
               (c[EW-2] ? d << (DATA_W - a) : '0);
   endfunction

   assign err_flag = err_q;
`endif

   // ready is held off until the first edge after reset release
   assign cmd_ready  = rdy_en_q &&
                       (count_q != CW'(FIFO_DEPTH));
   assign empty      = (count_q == '0);
   assign push       = cmd_valid && cmd_ready;
   assign fifo_count = count_q;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign {bs_left_right, bs_shift_rotate,
           bs_shift_amt, bs_data_in} = iss_q;

   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      mem_d       = mem_q;
      iss_d       = iss_q;
      res_data_d  = res_data_q;
      res_valid_d = res_valid_q;
      pop         = 1'b0;
`ifdef BS_SELF_CHECK_EN
      err_d       = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            res_data_d  = bs_data_out;
            res_valid_d = 1'b1;
            state_d     = RESP;
`ifdef BS_SELF_CHECK_EN
            if (bs_data_out != shf(iss_q))
               err_d = 1'b1;
`endif
         end
         RESP: begin
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = ISSUE;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (pop) begin
         iss_d    = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push) begin
         mem_d[wr_ptr_q] = {cmd_left_right,
                            cmd_shift_rotate,
                            cmd_amt, cmd_data};
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         iss_q       <= '0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         rdy_en_q    <= 1'b0;
`ifdef BS_SELF_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         iss_q       <= iss_d;
         res_data_q  <= res_data_d;
         res_valid_q <= res_valid_d;
         rdy_en_q    <= 1'b1;
`ifdef BS_SELF_CHECK_EN
         err_q       <= err_d;
`endif
      end
   end

   // queue storage needs no reset: occupancy is tracked by count_q
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_bs_cmd_sequencer.sv
// Scoreboard bench for bs_cmd_sequencer with a behavioural shifter model.
// Covers reset, latency, rotate/shift, backpressure, mid-run reset, random.
module tb_bs_cmd_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_data = '0;
   logic [4:0]  cmd_amt = '0;
   logic        cmd_left_right = 1'b0;
   logic        cmd_shift_rotate = 1'b0;
   logic [31:0] bs_data_in;
   logic [4:0]  bs_shift_amt;
   logic        bs_left_right;
   logic        bs_shift_rotate;
   logic [31:0] bs_data_out;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic [2:0]  fifo_count;
`ifdef BS_SELF_CHECK_EN
   logic        err_flag;
`endif

   logic        corrupt = 1'b0;
   int          n_chk = 0;
   int          n_fail = 0;
   int          n_res = 0;
   logic [31:0] last_res = '0;
   logic [31:0] expq [$];
   logic        held = 1'b0;
   logic [31:0] held_data = '0;

   always #5 clk = ~clk;

   bs_cmd_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_data         (cmd_data),
      .cmd_amt          (cmd_amt),
      .cmd_left_right   (cmd_left_right),
      .cmd_shift_rotate (cmd_shift_rotate),
      .bs_data_in       (bs_data_in),
      .bs_shift_amt     (bs_shift_amt),
      .bs_left_right    (bs_left_right),
      .bs_shift_rotate  (bs_shift_rotate),
      .bs_data_out      (bs_data_out),
      .res_valid        (res_valid),
      .res_ready        (res_ready),
      .res_data         (res_data),
`ifdef BS_SELF_CHECK_EN
      .err_flag         (err_flag),
`endif
      .fifo_count       (fifo_count)
   );

   // bit-by-bit source selection: output bit i takes input bit i-amt (left)
   function automatic logic [31:0] ref_shift(
      input logic [31:0] d,
      input logic [4:0]  amt,
      input logic        lr,
      input logic        rot
   );
      logic [31:0] r;
      int          j;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         j = lr ? i - int'(amt) : i + int'(amt);
         if (j < 0)
            r[i] = rot ? d[j + 32] : 1'b0;
         else if (j > 31)
            r[i] = rot ? d[j - 32] : 1'b0;
         else
            r[i] = d[j];
      end
      return r;
   endfunction

   always_comb
      bs_data_out = ref_shift(bs_data_in, bs_shift_amt,
                              bs_left_right, bs_shift_rotate)
                    ^ {31'b0, corrupt};

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   // monitor: push on accept, pop and compare on result handshake
   always @(negedge clk) begin
      logic [31:0] e;
      if (!reset) begin
         expq.delete();
         held = 1'b0;
      end else begin
         if (held) begin
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, held_data);
         end
         if (cmd_valid && cmd_ready)
            expq.push_back(ref_shift(cmd_data, cmd_amt,
                                     cmd_left_right,
                                     cmd_shift_rotate)
                           ^ {31'b0, corrupt});
         if (res_valid && res_ready) begin
            n_res++;
            last_res = res_data;
            if (expq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_result: got %0h expected none",
                        res_data);
            end else begin
               e = expq.pop_front();
               chk("result", res_data, e);
            end
         end
         held = res_valid && !res_ready;
         held_data = res_data;
      end
   end

   // call at posedge+1; returns at posedge+1 with cmd_valid low
   task automatic send(input logic [31:0] d,
                       input logic [4:0] a,
                       input logic lr,
                       input logic rot,
                       input int lim,
                       output bit ok);
      cmd_data = d;
      cmd_amt = a;
      cmd_left_right = lr;
      cmd_shift_rotate = rot;
      cmd_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < lim && !ok; t++) begin
         @(negedge clk);
         if (cmd_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
   endtask

   task automatic wait_n(input string nm, input int target);
      for (int t = 0; t < 40 && n_res < target; t++) begin
         @(posedge clk);
         #1;
      end
      chk(nm, n_res >= target, 1);
   endtask

   task automatic drain(input string nm);
      int t;
      res_ready = 1'b1;
      cmd_valid = 1'b0;
      for (t = 0; t < 100; t++) begin
         @(posedge clk);
         #1;
         if (expq.size() == 0 && !res_valid) break;
      end
      chk(nm, expq.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int acc, got, last, n0;
      logic [4:0] a;

      // reset held across two edges
      @(posedge clk);
      @(negedge clk);
      chk("rst_valid", res_valid, 0);
      chk("rst_data", res_data, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_bs_data", bs_data_in, 0);
      chk("rst_bs_amt", bs_shift_amt, 0);
      chk("rst_bs_lr", bs_left_right, 0);
      chk("rst_bs_rot", bs_shift_rotate, 0);
`ifdef BS_SELF_CHECK_EN
      chk("rst_err", err_flag, 0);
`endif
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rel_ready_low", cmd_ready, 0);
      @(negedge clk);
      chk("rel_ready_high", cmd_ready, 1);
      chk("rel_valid", res_valid, 0);

      // single left shift, latency N+3
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      cmd_data = 32'h0000_00F1;
      cmd_amt = 5'd4;
      cmd_left_right = 1'b1;
      cmd_shift_rotate = 1'b0;
      cmd_valid = 1'b1;
      @(negedge clk);
      chk("lat_accept", cmd_ready, 1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      chk("lat_n1", res_valid, 0);
      @(negedge clk);
      chk("lat_n2", res_valid, 0);
      @(negedge clk);
      chk("lat_n3", res_valid, 1);
      chk("lat_data", res_data, 32'h0000_0F10);
      @(negedge clk);
      chk("lat_idle", res_valid, 0);
      chk("lat_bs_hold", bs_data_in, 32'h0000_00F1);

      // right rotate then right logical shift
      @(posedge clk);
      #1;
      n0 = n_res;
      send(32'h8000_0001, 5'd1, 1'b0, 1'b1, 10, ok);
      chk("rot_accept", ok, 1);
      wait_n("rot_wait", n0 + 1);
      chk("rot_data", last_res, 32'hC000_0000);
      send(32'h8000_0001, 5'd1, 1'b0, 1'b0, 10, ok);
      chk("shr_accept", ok, 1);
      wait_n("shr_wait", n0 + 2);
      chk("shr_data", last_res, 32'h4000_0000);
      drain("drain_basic");

      // backpressure: five accepted, sixth refused
      res_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         send($urandom, 5'($urandom_range(0, 31)),
              1'($urandom), 1'($urandom), 4, ok);
         if (ok) acc++;
      end
      chk("bp_accepted", acc, 5);
      @(negedge clk);
      chk("bp_count", fifo_count, 4);
      chk("bp_ready", cmd_ready, 0);
      chk("bp_valid", res_valid, 1);
      @(posedge clk);
      #1 res_ready = 1'b1;
      got = 0;
      last = 0;
      for (int c = 0; c < 30 && got < 5; c++) begin
         @(negedge clk);
         if (res_valid) begin
            if (got > 0) chk("bp_gap", c - last, 2);
            last = c;
            got++;
         end
      end
      chk("bp_results", got, 5);
      @(posedge clk);
      #1;
      drain("drain_bp");

      // reset while in RESP with two queued
      res_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send($urandom, 5'($urandom_range(0, 31)),
              1'($urandom), 1'($urandom), 10, ok);
         chk("mr_accept", ok, 1);
      end
      ok = 1'b0;
      for (int t = 0; t < 10 && !ok; t++) begin
         @(negedge clk);
         if (res_valid && fifo_count == 3'd2) ok = 1'b1;
      end
      chk("mr_setup", ok, 1);
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("mr_valid", res_valid, 0);
      chk("mr_count", fifo_count, 0);
      chk("mr_ready", cmd_ready, 0);
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      n0 = n_res;
      repeat (10) @(posedge clk);
      #1;
      chk("mr_no_results", n_res, n0);

      // random traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0)
            a = $urandom_range(0, 1) == 0 ? 5'd0 : 5'd31;
         else
            a = 5'($urandom_range(0, 31));
         cmd_valid = ($urandom_range(0, 99) < 60);
         cmd_data = $urandom;
         cmd_amt = a;
         cmd_left_right = 1'($urandom);
         cmd_shift_rotate = 1'($urandom);
         res_ready = ($urandom_range(0, 99) < 50);
         @(posedge clk);
         #1;
      end
      drain("drain_random");
      chk("random_count", fifo_count, 0);

`ifdef BS_SELF_CHECK_EN
      chk("err_clean", err_flag, 0);
      n0 = n_res;
      corrupt = 1'b1;
      send(32'h1234_5678, 5'd3, 1'b1, 1'b0, 10, ok);
      chk("err_accept", ok, 1);
      wait_n("err_wait", n0 + 1);
      corrupt = 1'b0;
      @(negedge clk);
      chk("err_set", err_flag, 1);
      repeat (5) @(negedge clk);
      chk("err_sticky", err_flag, 1);
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("err_cleared", err_flag, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
